// File: rtl/td4_exec_controller.sv
// td4_exec_controller: 16x8 program memory plus run/step/break sequencing
// and execute-enable pacing for a TD4-style CPU core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE 00 | stopped, program memory writable, waiting for run/step edge
// RUN  01 | free-running, exec_mode pulsed on each divider tick
// STEP 10 | single cycle with exec_mode high, then back to IDLE
// BREAK11 | stopped on a breakpoint hit, memory writable, resumable
module td4_exec_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [3:0] load_addr,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       run_req,
  input  logic       step_req,
  input  logic       halt_req,
  input  logic [1:0] rate_sel,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] cpu_pc,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       exec_mode,
  output logic [1:0] state,
  output logic [7:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        skip_bp_q, skip_bp_d;
  logic [7:0]  instr_count_q, instr_count_d;
  logic        run_prev_q, run_prev_d;
  logic        step_prev_q, step_prev_d;
  logic [7:0]  mem_q [0:15];
  logic [7:0]  mem_d [0:15];

  logic        run_edge;
  logic        step_edge;
  logic [7:0]  term_val;
  logic        tick;
  logic        bp_hit;

  assign run_edge    = run_req & ~run_prev_q;
  assign step_edge   = step_req & ~step_prev_q;
  assign run_prev_d  = run_req;
  assign step_prev_d = step_req;

  assign load_ready  = (state_q == ST_IDLE) || (state_q == ST_BREAK);
  assign opcode      = mem_q[cpu_pc][7:4];
  assign immediate   = mem_q[cpu_pc][3:0];
  assign state       = state_q;
  assign instr_count = instr_count_q;

  // Divider terminal value; read live so a rate change applies at once.
  always_comb begin
    term_val = 8'd0;
    case (rate_sel)
      2'b00:   term_val = 8'd0;
      2'b01:   term_val = 8'd3;
      2'b10:   term_val = 8'd15;
      default: term_val = 8'd255;
    endcase
  end

  // Program memory write port; writes only while stopped.
  always_comb begin
    mem_d = mem_q;
    if (load_valid && load_ready) begin
      mem_d[load_addr] = load_data;
    end
  end

  // Next-state, divider, breakpoint skip and execute-enable decode.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    skip_bp_d = skip_bp_q;
    exec_mode = 1'b0;
    tick      = 1'b0;
    bp_hit    = 1'b0;
    case (state_q)
      ST_IDLE, ST_BREAK: begin
        if (!halt_req) begin
          if (run_edge) begin
            state_d   = ST_RUN;
            div_cnt_d = 8'd0;
            // resuming from a break must execute the breakpoint instruction once
            skip_bp_d = (state_q == ST_BREAK);
          end else if (step_edge) begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        exec_mode = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RUN: begin
        tick   = (div_cnt_q == term_val);
        bp_hit = tick && bp_en && (cpu_pc == bp_addr) && !skip_bp_q;
        if (halt_req) begin
          state_d = ST_IDLE;
        end else begin
          // plain increment wraps 255->0 when a rate change left us above T
          div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
          if (bp_hit) begin
            state_d = ST_BREAK;
          end else if (tick) begin
            exec_mode = 1'b1;
            skip_bp_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_count_d = instr_count_q + {7'd0, exec_mode};

  // State, counters, edge detectors and memory registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      div_cnt_q     <= 8'd0;
      skip_bp_q     <= 1'b0;
      instr_count_q <= 8'd0;
      run_prev_q    <= 1'b0;
      step_prev_q   <= 1'b0;
      mem_q         <= '{default: 8'h00};
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      skip_bp_q     <= skip_bp_d;
      instr_count_q <= instr_count_d;
      run_prev_q    <= run_prev_d;
      step_prev_q   <= step_prev_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: doc/td4_exec_controller.md
TD4_EXEC_CONTROLLER -- requirements
Module: td4_exec_controller

Interface
REQ-001 SHALL have parameter none; all widths are fixed.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load_valid  input  1  program-memory write strobe.
REQ-005 load_addr  input  4  program-memory write address.
REQ-006 load_data  input  8  instruction word: [7:4] opcode, [3:0] immediate.
REQ-007 load_ready  output  1  high when state is IDLE or BREAK.
REQ-008 run_req  input  1  start continuous execution (rising-edge sensitive).
REQ-009 step_req  input  1  execute one instruction (rising-edge sensitive).
REQ-010 halt_req  input  1  stop execution (level sensitive).
REQ-011 rate_sel  input  2  run rate: 00 every cycle, 01 every 4, 10 every 16, 11 every 256.
REQ-012 bp_en  input  1  breakpoint enable.
REQ-013 bp_addr  input  4  breakpoint PC.
REQ-014 cpu_pc  input  4  current PC from the CPU core.
REQ-015 opcode  output  4  mem[cpu_pc][7:4], combinational read.
REQ-016 immediate  output  4  mem[cpu_pc][3:0], combinational read.
REQ-017 exec_mode  output  1  one-cycle execute enable to the CPU core.
REQ-018 state  output  2  IDLE=00, RUN=01, STEP=10, BREAK=11.
REQ-019 instr_count  output  8  count of exec_mode pulses.

Function
REQ-020 SHALL hold a 16x8 program memory; load_valid with load_ready high writes load_data to mem[load_addr] on the clock edge; load_valid otherwise ignored.
REQ-021 Write and read of the same address in one cycle SHALL show old contents on opcode/immediate until the next cycle.
REQ-022 SHALL detect rising edges of run_req and step_req via registers reset to 0; a level held high across reset release counts as an edge on the first clock.
REQ-023 IDLE/BREAK: halt_req high -> stay; else run edge -> RUN; else step edge -> STEP; run beats step when simultaneous.
REQ-024 STEP SHALL last exactly one cycle with exec_mode=1, then go to IDLE; breakpoint ignored in STEP.
REQ-025 RUN: 8-bit divider div_cnt cleared on RUN entry, incremented each RUN cycle, cleared when it equals terminal value T (0, 3, 15, 255 for rate_sel 00..11); a tick occurs when div_cnt==T.
REQ-026 rate_sel change during RUN SHALL take effect immediately; if div_cnt already exceeds new T, counter continues to 255, wraps to 0, then ticks at T.
REQ-027 RUN tick with halt_req low and no breakpoint hit SHALL assert exec_mode for that cycle.
REQ-028 Breakpoint hit = bp_en && cpu_pc==bp_addr && skip_bp==0 on a tick; hit -> no exec_mode, next state BREAK.
REQ-029 skip_bp SHALL be set on entry to RUN from BREAK, cleared after the first exec_mode pulse in RUN, so resume executes the breakpoint instruction once.
REQ-030 halt_req high in RUN SHALL suppress exec_mode that cycle and go to IDLE next cycle; halt outranks tick and breakpoint.
REQ-031 instr_count SHALL increment by 1 on every exec_mode cycle, wrapping 255->0.
REQ-032 exec_mode SHALL never be high in IDLE or BREAK.

Reset
REQ-033 rst_n low SHALL asynchronously force state=IDLE, exec_mode=0, div_cnt=0, skip_bp=0, instr_count=0, edge registers=0, all 16 memory words=0x00 (opcode/immediate=0).
REQ-034 Reset mid-RUN or mid-STEP SHALL abort with no further exec_mode pulse.

Verification
REQ-035 Load mem[0]=0xC5, cpu_pc=0, step edge -> exactly one exec_mode cycle with opcode=C, immediate=5; state STEP->IDLE; instr_count=1.
REQ-036 rate_sel=01, run edge -> exec_mode high on RUN cycles 4, 8, 12; halt_req -> IDLE, no further pulses.
REQ-037 bp_en=1, bp_addr=3, rate_sel=00, cpu_pc stepping 0..3 -> pulses at pc 0,1,2, none at 3, state=BREAK; run edge -> one pulse at pc 3, run continues.
REQ-038 load_valid with addr 2, data 0xFF during RUN -> mem[2] unchanged, load_ready=0.
REQ-039 rst_n low in RUN with instr_count=7 -> immediately state=00, exec_mode=0, instr_count=0, opcode/immediate=0.
REQ-040 run edge with halt_req high in IDLE -> state remains IDLE, no exec_mode.
